// File: rtl/gray_counter_if.sv
// Control/status bundle for gray_counter: counter controls, Gray/binary pointer
// outputs and the independent Gray-to-binary decode path.
interface gray_counter_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_bin;
   logic [WIDTH-1:0] bin;
   logic [WIDTH-1:0] gray;
   logic             wrap;
   logic [WIDTH-1:0] g_in;
   logic             g_in_valid;
   logic [WIDTH-1:0] bin_out;
   logic             bin_out_valid;

   modport master (
      output en, up, load, load_bin, g_in, g_in_valid,
      input  bin, gray, wrap, bin_out, bin_out_valid
   );

   modport slave (
      input  en, up, load, load_bin, g_in, g_in_valid,
      output bin, gray, wrap, bin_out, bin_out_valid
   );
endinterface

// File: rtl/gray_counter.sv
// Up/down loadable Gray pointer with registered Gray output and wrap pulse,
// plus an independent registered Gray-to-binary decoder.
module gray_counter #(
   parameter int               WIDTH = 4,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   gray_counter_if.slave bus
);

   function automatic logic [WIDTH-1:0] enc(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [WIDTH-1:0] dec(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   logic [WIDTH-1:0] bin_q,  bin_d;
   logic [WIDTH-1:0] gray_q, gray_d;
   logic             wrap_q, wrap_d;
   logic [WIDTH-1:0] dec_q,  dec_d;
   logic             vld_q,  vld_d;

   always_comb begin
      bin_d  = bin_q;
      gray_d = gray_q;
      wrap_d = 1'b0;
      if (bus.load) begin
         bin_d  = bus.load_bin;
         gray_d = enc(bus.load_bin);
      end else if (bus.en) begin
         if (bus.up) begin
            bin_d  = bin_q + 1'b1;
            wrap_d = &bin_q;
         end else begin
            bin_d  = bin_q - 1'b1;
            wrap_d = ~|bin_q;
         end
         // Gray is registered from the next binary value so CDC paths see a clean flop.
         gray_d = enc(bin_d);
      end
   end

   always_comb begin
      dec_d = dec_q;
      vld_d = bus.g_in_valid;
      if (bus.g_in_valid) dec_d = dec(bus.g_in);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_q  <= INIT;
         gray_q <= enc(INIT);
         wrap_q <= 1'b0;
         dec_q  <= '0;
         vld_q  <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
         wrap_q <= wrap_d;
         dec_q  <= dec_d;
         vld_q  <= vld_d;
      end
   end

   assign bus.bin           = bin_q;
   assign bus.gray          = gray_q;
   assign bus.wrap          = wrap_q;
   assign bus.bin_out       = dec_q;
   assign bus.bin_out_valid = vld_q;

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter (WIDTH=4, INIT=0) with hand-computed vectors.
module tb_gray_counter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   gray_counter_if #(.WIDTH(4)) bus ();
   gray_counter #(.WIDTH(4), .INIT(4'd0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.en = 0; bus.up = 0; bus.load = 0; bus.load_bin = '0;
      bus.g_in = '0; bus.g_in_valid = 0;
   endtask

   task automatic test_reset();
      idle();
      #2 rst_n = 1'b1;
      bus.load = 1; bus.load_bin = 4'b1010; bus.g_in = 4'b1111; bus.g_in_valid = 1;
      tick();
      bus.load = 0; bus.g_in_valid = 0;
      #3 rst_n = 1'b0;
      #1;
      n_vec++; if (bus.bin !== 4'b0000) begin n_err++; $display("FAIL reset_bin got %b want 0000", bus.bin); end
      n_vec++; if (bus.gray !== 4'b0000) begin n_err++; $display("FAIL reset_gray got %b want 0000", bus.gray); end
      n_vec++; if (bus.wrap !== 1'b0) begin n_err++; $display("FAIL reset_wrap got %b want 0", bus.wrap); end
      n_vec++; if (bus.bin_out !== 4'b0000) begin n_err++; $display("FAIL reset_bin_out got %b want 0000", bus.bin_out); end
      n_vec++; if (bus.bin_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_bin_out_valid got %b want 0", bus.bin_out_valid); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_count_up();
      logic [3:0] gtab [16];
      logic [3:0] prev;
      gtab = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
               4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
      idle();
      bus.load = 1; bus.load_bin = 4'b0000;
      tick();
      bus.load = 0; bus.en = 1; bus.up = 1;
      prev = bus.gray;
      for (int i = 0; i < 16; i++) begin
         tick();
         n_vec++; if (bus.gray !== gtab[i]) begin n_err++; $display("FAIL up_gray step %0d got %b want %b", i, bus.gray, gtab[i]); end
         n_vec++; if (bus.bin !== 4'((i + 1) % 16)) begin n_err++; $display("FAIL up_bin step %0d got %b want %b", i, bus.bin, 4'((i + 1) % 16)); end
         n_vec++; if (bus.wrap !== (i == 15)) begin n_err++; $display("FAIL up_wrap step %0d got %b want %b", i, bus.wrap, (i == 15)); end
         n_vec++; if ($countones(bus.gray ^ prev) != 1) begin n_err++; $display("FAIL up_onebit step %0d got %b->%b want one bit change", i, prev, bus.gray); end
         prev = bus.gray;
      end
      idle();
      tick();
      n_vec++; if (bus.wrap !== 1'b0) begin n_err++; $display("FAIL hold_wrap got %b want 0", bus.wrap); end
      n_vec++; if (bus.bin !== 4'b0000) begin n_err++; $display("FAIL hold_bin got %b want 0000", bus.bin); end
   endtask

   task automatic test_load_priority();
      idle();
      bus.load = 1; bus.load_bin = 4'b1101; bus.en = 1; bus.up = 1;
      tick();
      n_vec++; if (bus.bin !== 4'b1101) begin n_err++; $display("FAIL load_bin got %b want 1101", bus.bin); end
      n_vec++; if (bus.gray !== 4'b1011) begin n_err++; $display("FAIL load_gray got %b want 1011", bus.gray); end
      n_vec++; if (bus.wrap !== 1'b0) begin n_err++; $display("FAIL load_wrap got %b want 0", bus.wrap); end
      bus.load = 0;
      tick();
      n_vec++; if (bus.bin !== 4'b1110) begin n_err++; $display("FAIL load_step_bin got %b want 1110", bus.bin); end
      n_vec++; if (bus.gray !== 4'b1001) begin n_err++; $display("FAIL load_step_gray got %b want 1001", bus.gray); end
      // load of the current all-ones value with en/up set: wrap suppressed, value held
      bus.en = 0; bus.load = 1; bus.load_bin = 4'b1111;
      tick();
      bus.en = 1; bus.up = 1;
      tick();
      n_vec++; if (bus.bin !== 4'b1111) begin n_err++; $display("FAIL load_same_bin got %b want 1111", bus.bin); end
      n_vec++; if (bus.gray !== 4'b1000) begin n_err++; $display("FAIL load_same_gray got %b want 1000", bus.gray); end
      n_vec++; if (bus.wrap !== 1'b0) begin n_err++; $display("FAIL load_wrap_cond got %b want 0", bus.wrap); end
      idle();
   endtask

   task automatic test_count_down();
      idle();
      bus.load = 1; bus.load_bin = 4'b0000;
      tick();
      bus.load = 0; bus.en = 1; bus.up = 0;
      tick();
      n_vec++; if (bus.bin !== 4'b1111) begin n_err++; $display("FAIL down_bin got %b want 1111", bus.bin); end
      n_vec++; if (bus.gray !== 4'b1000) begin n_err++; $display("FAIL down_gray got %b want 1000", bus.gray); end
      n_vec++; if (bus.wrap !== 1'b1) begin n_err++; $display("FAIL down_wrap got %b want 1", bus.wrap); end
      tick();
      n_vec++; if (bus.bin !== 4'b1110) begin n_err++; $display("FAIL down2_bin got %b want 1110", bus.bin); end
      n_vec++; if (bus.gray !== 4'b1001) begin n_err++; $display("FAIL down2_gray got %b want 1001", bus.gray); end
      n_vec++; if (bus.wrap !== 1'b0) begin n_err++; $display("FAIL down2_wrap got %b want 0", bus.wrap); end
      idle();
   endtask

   task automatic test_decoder();
      idle();
      bus.g_in = 4'b1011; bus.g_in_valid = 1;
      tick();
      n_vec++; if (bus.bin_out !== 4'b1101) begin n_err++; $display("FAIL dec1_bin_out got %b want 1101", bus.bin_out); end
      n_vec++; if (bus.bin_out_valid !== 1'b1) begin n_err++; $display("FAIL dec1_valid got %b want 1", bus.bin_out_valid); end
      bus.g_in = 4'b0100;
      tick();
      n_vec++; if (bus.bin_out !== 4'b0111) begin n_err++; $display("FAIL dec2_bin_out got %b want 0111", bus.bin_out); end
      n_vec++; if (bus.bin_out_valid !== 1'b1) begin n_err++; $display("FAIL dec2_valid got %b want 1", bus.bin_out_valid); end
      bus.g_in = 4'b1111; bus.g_in_valid = 0;
      tick();
      n_vec++; if (bus.bin_out !== 4'b0111) begin n_err++; $display("FAIL dec_hold_bin_out got %b want 0111", bus.bin_out); end
      n_vec++; if (bus.bin_out_valid !== 1'b0) begin n_err++; $display("FAIL dec_hold_valid got %b want 0", bus.bin_out_valid); end
      idle();
   endtask

   task automatic test_reset_mid();
      idle();
      bus.load = 1; bus.load_bin = 4'b0101;
      tick();
      bus.load = 0; bus.en = 1; bus.up = 1; bus.g_in = 4'b1000; bus.g_in_valid = 1;
      tick();
      n_vec++; if (bus.bin !== 4'b0110) begin n_err++; $display("FAIL mid_pre_bin got %b want 0110", bus.bin); end
      n_vec++; if (bus.bin_out_valid !== 1'b1 || bus.bin_out !== 4'b1111) begin n_err++; $display("FAIL mid_pre_dec got %b/%b want 1111/1", bus.bin_out, bus.bin_out_valid); end
      #2 rst_n = 1'b0;
      #1;
      n_vec++; if (bus.bin !== 4'b0000) begin n_err++; $display("FAIL mid_rst_bin got %b want 0000", bus.bin); end
      n_vec++; if (bus.gray !== 4'b0000) begin n_err++; $display("FAIL mid_rst_gray got %b want 0000", bus.gray); end
      n_vec++; if (bus.wrap !== 1'b0) begin n_err++; $display("FAIL mid_rst_wrap got %b want 0", bus.wrap); end
      n_vec++; if (bus.bin_out !== 4'b0000) begin n_err++; $display("FAIL mid_rst_bin_out got %b want 0000", bus.bin_out); end
      n_vec++; if (bus.bin_out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got %b want 0", bus.bin_out_valid); end
      bus.g_in_valid = 0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      n_vec++; if (bus.bin !== 4'b0001) begin n_err++; $display("FAIL mid_restart_bin got %b want 0001", bus.bin); end
      n_vec++; if (bus.gray !== 4'b0001) begin n_err++; $display("FAIL mid_restart_gray got %b want 0001", bus.gray); end
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_count_up();
      test_load_priority();
      test_count_down();
      test_decoder();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
